reflet_vga_term: RTL and testbench

//  Terminal-style front end placed directly upstream of reflet_VGA's text layer.

---
 rtl/reflet_vga_term_pkg.sv | 16 +
 rtl/reflet_vga_cursor.sv | 63 ++++++
 rtl/reflet_vga_term.sv | 153 +++++++++++++++
 tb/tb_reflet_vga_term.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_vga_term_pkg.sv
// Shared constants and encodings for the reflet_VGA terminal front end.
package reflet_vga_term_pkg;

  localparam logic [7:0] CC_BS    = 8'h08;
  localparam logic [7:0] CC_LF    = 8'h0A;
  localparam logic [7:0] CC_FF    = 8'h0C;
  localparam logic [7:0] CC_CR    = 8'h0D;
  localparam logic [7:0] CC_SPACE = 8'h20;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;

  typedef enum logic [2:0] {
    OP_NONE, OP_INC, OP_NEWLINE, OP_CR, OP_BACK, OP_HOME
  } cur_op_t;

endpackage

// File: rtl/reflet_vga_cursor.sv
// Column/row counter pair with terminal-style moves; wraps by compare, not modulo.
module reflet_vga_cursor
  import reflet_vga_term_pkg::*;
#(
  parameter int COLS    = 80,
  parameter int ROWS    = 30,
  parameter int H_WIDTH = 7,
  parameter int V_WIDTH = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  cur_op_t            op,
  output logic [H_WIDTH-1:0] col,
  output logic [V_WIDTH-1:0] row,
  output logic [H_WIDTH-1:0] inc_col,
  output logic [V_WIDTH-1:0] inc_row,
  output logic [H_WIDTH-1:0] back_col,
  output logic [V_WIDTH-1:0] back_row,
  output logic               last
);

  localparam logic [H_WIDTH-1:0] COL_MAX = H_WIDTH'(COLS - 1);
  localparam logic [V_WIDTH-1:0] ROW_MAX = V_WIDTH'(ROWS - 1);

  logic               col_end, row_end;
  logic [V_WIDTH-1:0] nl_row;

  always_comb begin
    col_end  = (col == COL_MAX);
    row_end  = (row == ROW_MAX);
    nl_row   = row_end ? '0 : row + 1'b1;
    inc_col  = col_end ? '0 : col + 1'b1;
    inc_row  = col_end ? nl_row : row;
    last     = col_end && row_end;
    back_col = '0;
    back_row = '0;
    // Backspace from column 0 climbs to the end of the previous row; (0,0) is sticky.
    if (col != '0) begin
      back_col = col - 1'b1;
      back_row = row;
    end else if (row != '0) begin
      back_col = COL_MAX;
      back_row = row - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else begin
      case (op)
        OP_INC:     begin col <= inc_col;  row <= inc_row;  end
        OP_NEWLINE: begin col <= '0;       row <= nl_row;   end
        OP_CR:      col <= '0;
        OP_BACK:    begin col <= back_col; row <= back_row; end
        OP_HOME:    begin col <= '0;       row <= '0;       end
        default:    ;
      endcase
    end
  end

endmodule

// File: rtl/reflet_vga_term.sv
// Byte-stream terminal driving reflet_VGA's text write port, one cell per strobe.
module reflet_vga_term
  import reflet_vga_term_pkg::*;
#(
  parameter int COLOR_DEPTH = 2,
  parameter int COLS        = 80,
  parameter int ROWS        = 30,
  parameter int H_WIDTH     = 7,
  parameter int V_WIDTH     = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_char,
  input  logic [COLOR_DEPTH-1:0] R_fg,
  input  logic [COLOR_DEPTH-1:0] G_fg,
  input  logic [COLOR_DEPTH-1:0] B_fg,
  input  logic [COLOR_DEPTH-1:0] R_bg,
  input  logic [COLOR_DEPTH-1:0] G_bg,
  input  logic [COLOR_DEPTH-1:0] B_bg,
  output logic                   write_txt,
  output logic [H_WIDTH-1:0]     h_pixel,
  output logic [V_WIDTH-1:0]     v_pixel,
  output logic [7:0]             char_out,
  output logic [COLOR_DEPTH-1:0] R_out,
  output logic [COLOR_DEPTH-1:0] G_out,
  output logic [COLOR_DEPTH-1:0] B_out,
  output logic [COLOR_DEPTH-1:0] R_bg_out,
  output logic [COLOR_DEPTH-1:0] G_bg_out,
  output logic [COLOR_DEPTH-1:0] B_bg_out,
  output logic [H_WIDTH-1:0]     cur_col,
  output logic [V_WIDTH-1:0]     cur_row,
  output logic                   busy
);

  state_t             state, state_nxt;
  cur_op_t            cur_op, sweep_op;
  logic [7:0]         byte_q;
  logic               accept;
  logic [H_WIDTH-1:0] back_col, sweep_col, sweep_inc_col;
  logic [V_WIDTH-1:0] back_row, sweep_row, sweep_inc_row;
  logic               sweep_last;
  logic [H_WIDTH-1:0] unused_cur_inc_col, unused_sweep_back_col;
  logic [V_WIDTH-1:0] unused_cur_inc_row, unused_sweep_back_row;
  logic               unused_cur_last;
  logic               unused_sweep_pos;

  assign in_ready = (state == S_IDLE) && !reset;
  assign busy     = !in_ready;
  assign accept   = in_valid && in_ready;
  assign unused_sweep_pos = ^{sweep_col, sweep_row};

  reflet_vga_cursor #(.COLS(COLS), .ROWS(ROWS), .H_WIDTH(H_WIDTH), .V_WIDTH(V_WIDTH)) u_cursor (
    .clk(clk), .reset(reset), .op(cur_op),
    .col(cur_col), .row(cur_row),
    .inc_col(unused_cur_inc_col), .inc_row(unused_cur_inc_row),
    .back_col(back_col), .back_row(back_row),
    .last(unused_cur_last)
  );

  // Sweep holds the cell currently on the outputs during CLEAR; parked at (0,0) otherwise.
  reflet_vga_cursor #(.COLS(COLS), .ROWS(ROWS), .H_WIDTH(H_WIDTH), .V_WIDTH(V_WIDTH)) u_sweep (
    .clk(clk), .reset(reset), .op(sweep_op),
    .col(sweep_col), .row(sweep_row),
    .inc_col(sweep_inc_col), .inc_row(sweep_inc_row),
    .back_col(unused_sweep_back_col), .back_row(unused_sweep_back_row),
    .last(sweep_last)
  );

  always_comb begin
    state_nxt = state;
    cur_op    = OP_NONE;
    sweep_op  = OP_NONE;
    case (state)
      S_IDLE: begin
        sweep_op = OP_HOME;
        if (accept) state_nxt = (in_char == CC_FF) ? S_CLEAR : S_WRITE;
      end
      S_WRITE: begin
        state_nxt = S_IDLE;
        case (byte_q)
          CC_LF:   cur_op = OP_NEWLINE;
          CC_CR:   cur_op = OP_CR;
          CC_BS:   cur_op = OP_BACK;
          default: cur_op = OP_INC;
        endcase
      end
      S_CLEAR: begin
        if (sweep_last) begin
          state_nxt = S_IDLE;
          cur_op    = OP_HOME;
        end else begin
          sweep_op = OP_INC;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Write port is loaded at accept so the strobe lands in the cycle right after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_txt <= 1'b0;
      h_pixel   <= '0;
      v_pixel   <= '0;
      char_out  <= '0;
      byte_q    <= '0;
      {R_out, G_out, B_out}          <= '0;
      {R_bg_out, G_bg_out, B_bg_out} <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          write_txt <= 1'b0;
          if (accept) begin
            byte_q <= in_char;
            if (in_char != CC_LF && in_char != CC_CR) begin
              write_txt <= 1'b1;
              {R_out, G_out, B_out}          <= {R_fg, G_fg, B_fg};
              {R_bg_out, G_bg_out, B_bg_out} <= {R_bg, G_bg, B_bg};
              char_out <= CC_SPACE;
              h_pixel  <= '0;
              v_pixel  <= '0;
              if (in_char == CC_BS) begin
                h_pixel <= back_col;
                v_pixel <= back_row;
              end else if (in_char != CC_FF) begin
                h_pixel  <= cur_col;
                v_pixel  <= cur_row;
                char_out <= in_char;
              end
            end
          end
        end
        S_CLEAR: begin
          if (sweep_last) begin
            write_txt <= 1'b0;
          end else begin
            h_pixel <= sweep_inc_col;
            v_pixel <= sweep_inc_row;
          end
        end
        default: write_txt <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_vga_term.sv
// Directed bench for reflet_vga_term with a write scoreboard fed by a cursor model.
module tb_reflet_vga_term;

  logic       clk, reset, in_valid, in_ready, write_txt, busy;
  logic [7:0] in_char, char_out;
  logic [1:0] R_fg, G_fg, B_fg, R_bg, G_bg, B_bg;
  logic [1:0] R_out, G_out, B_out, R_bg_out, G_bg_out, B_bg_out;
  logic [6:0] h_pixel, cur_col;
  logic [5:0] v_pixel, cur_row;

  typedef struct packed {
    logic [6:0] h;
    logic [5:0] v;
    logic [7:0] c;
    logic [5:0] fg;
    logic [5:0] bg;
  } wr_t;

  wr_t        sb[$];
  int         checks = 0, errors = 0, wr_cnt = 0;
  int         mcol = 0, mrow = 0;
  logic [6:0] last_h;
  logic [5:0] last_v;

  reflet_vga_term dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .R_fg(R_fg), .G_fg(G_fg), .B_fg(B_fg), .R_bg(R_bg), .G_bg(G_bg), .B_bg(B_bg),
    .write_txt(write_txt), .h_pixel(h_pixel), .v_pixel(v_pixel), .char_out(char_out),
    .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .R_bg_out(R_bg_out), .G_bg_out(G_bg_out), .B_bg_out(B_bg_out),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic push(input int c, input int r, input logic [7:0] ch);
    sb.push_back('{h: 7'(c), v: 6'(r), c: ch, fg: {R_fg, G_fg, B_fg}, bg: {R_bg, G_bg, B_bg}});
  endtask

  task automatic model(input logic [7:0] b);
    case (b)
      8'h0A: begin mcol = 0; mrow = (mrow == 29) ? 0 : mrow + 1; end
      8'h0D: mcol = 0;
      8'h0C: begin
        for (int r = 0; r < 30; r++)
          for (int c = 0; c < 80; c++) push(c, r, 8'h20);
        mcol = 0; mrow = 0;
      end
      8'h08: begin
        if (mcol > 0) mcol--;
        else if (mrow > 0) begin mcol = 79; mrow--; end
        push(mcol, mrow, 8'h20);
      end
      default: begin
        push(mcol, mrow, b);
        if (mcol == 79) begin mcol = 0; mrow = (mrow == 29) ? 0 : mrow + 1; end
        else mcol++;
      end
    endcase
  endtask

  // Drives one byte and returns just after the accepting edge.
  task automatic send(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = b;
    while (!in_ready && guard < 5000) begin @(negedge clk); guard++; end
    if (guard >= 5000) chk("handshake_timeout", 64'(guard), 0);
    model(b);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic step(input logic [7:0] b);
    int c0;
    c0 = wr_cnt;
    send(b);
    @(negedge clk);
    chk("ready_low", in_ready, 0);
    @(negedge clk);
    chk("ready_back", in_ready, 1);
    chk("cur_col", cur_col, 64'(mcol));
    chk("cur_row", cur_row, 64'(mrow));
    chk("write_count", 64'(wr_cnt - c0), (b == 8'h0A || b == 8'h0D) ? 0 : 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    mcol = 0; mrow = 0;
  endtask

  always @(negedge clk) begin
    if (write_txt === 1'b1) begin
      wr_cnt++;
      last_h = h_pixel;
      last_v = v_pixel;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write: got write at (%0d,%0d) char %0h want none", h_pixel, v_pixel, char_out);
      end else begin
        chk("write", 64'({h_pixel, v_pixel, char_out, R_out, G_out, B_out, R_bg_out, G_bg_out, B_bg_out}),
            64'(sb.pop_front()));
      end
    end
  end

  initial begin
    int c0, waits;
    reset = 1'b1; in_valid = 1'b0; in_char = 8'h00;
    R_fg = 2'b11; G_fg = 2'b00; B_fg = 2'b00;
    R_bg = 2'b00; G_bg = 2'b11; B_bg = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_write_txt", write_txt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cursor", {cur_col, cur_row}, 0);
    chk("rst_data", {h_pixel, v_pixel, char_out, R_out, G_bg_out}, 0);

    // single printable byte
    send(8'h41);
    @(negedge clk);
    chk("t1_strobe", write_txt, 1);
    chk("t1_pos", {h_pixel, v_pixel}, 0);
    chk("t1_char", char_out, 8'h41);
    chk("t1_R_out", R_out, 2'b11);
    chk("t1_G_bg_out", G_bg_out, 2'b11);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_strobe_end", write_txt, 0);
    chk("t1_ready", in_ready, 1);
    chk("t1_cursor", {cur_col, cur_row}, {7'd1, 6'd0});
    chk("t1_hold_char", char_out, 8'h41);

    // full row of control-range glyphs
    do_reset();
    for (int i = 0; i < 80; i++) step(8'h02);
    chk("t2_last_write", {last_h, last_v}, {7'd79, 6'd0});
    chk("t2_cursor", {cur_col, cur_row}, {7'd0, 6'd1});

    // LF / CR, including row wrap; different colour on the filler bytes
    do_reset();
    R_fg = 2'b01; B_fg = 2'b10; B_bg = 2'b01;
    step(8'h0A); step(8'h0A);
    for (int i = 0; i < 5; i++) step(8'h7F);
    chk("t3_at_5_2", {cur_col, cur_row}, {7'd5, 6'd2});
    step(8'h0A);
    chk("t3_lf", {cur_col, cur_row}, {7'd0, 6'd3});
    for (int i = 0; i < 26; i++) step(8'h0A);
    for (int i = 0; i < 5; i++) step(8'h00);
    chk("t3_at_5_29", {cur_col, cur_row}, {7'd5, 6'd29});
    step(8'h0A);
    chk("t3_lf_wrap", {cur_col, cur_row}, 0);
    step(8'h0A); step(8'h0A);
    for (int i = 0; i < 5; i++) step(8'h33);
    step(8'h0D);
    chk("t3_cr", {cur_col, cur_row}, {7'd0, 6'd2});
    R_fg = 2'b11; B_fg = 2'b00; B_bg = 2'b00;

    // backspace across a row boundary and at the origin
    do_reset();
    step(8'h0A);
    step(8'h08);
    chk("t4_bs_write", {last_h, last_v, char_out}, {7'd79, 6'd0, 8'h20});
    chk("t4_bs_cursor", {cur_col, cur_row}, {7'd79, 6'd0});
    step(8'h0D);
    step(8'h08);
    chk("t4_bs_origin_write", {last_h, last_v, char_out}, {7'd0, 6'd0, 8'h20});
    chk("t4_bs_origin_cursor", {cur_col, cur_row}, 0);

    // clear screen with in_valid held high throughout
    step(8'h45);
    c0 = wr_cnt;
    send(8'h0C);
    in_valid = 1'b1;
    in_char  = 8'h41;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 3000) begin waits++; @(negedge clk); end
    in_valid = 1'b0;
    chk("t5_busy_cycles", 64'(waits), 2400);
    chk("t5_write_count", 64'(wr_cnt - c0), 2400);
    chk("t5_last_write", {last_h, last_v}, {7'd79, 6'd29});
    chk("t5_cursor", {cur_col, cur_row}, 0);
    chk("t5_sb_drained", 64'(sb.size()), 0);
    repeat (2) @(negedge clk);
    chk("t5_not_consumed", write_txt, 0);
    chk("t5_cursor_still", {cur_col, cur_row}, 0);

    // reset during a clear abandons it
    step(8'h41); step(8'h42);
    send(8'h0C);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    mcol = 0; mrow = 0;
    @(negedge clk);
    chk("t6_write_off", write_txt, 0);
    chk("t6_ready", in_ready, 1);
    chk("t6_cursor", {cur_col, cur_row}, 0);
    step(8'h41);
    chk("t6_after_write", {last_h, last_v, char_out}, {7'd0, 6'd0, 8'h41});

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
